// File: rtl/pll_pkg.sv
// -----------------------------------------------------------------------------
// pll_pkg
// Shared types and constants for the PLL lock / reset sequencer.
//   pll_state_e : 2-bit sequencer state encoding
//   LOSS_W      : width of the saturating lock-loss counter
//   cnt_width() : bit width needed to hold values 0..n-1 (minimum 1)
// -----------------------------------------------------------------------------
package pll_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } pll_state_e;

    localparam int LOSS_W = 8;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pll_lock_reset_if.sv
// -----------------------------------------------------------------------------
// pll_lock_reset_if
// Signal bundle between the PLL lock sequencer and its environment.
//   lock_async : raw PLL LOCK, asynchronous to the clock
//   loss_clr   : synchronous clear of loss_count
//   reset      : active-high design reset (high in every state except RUN)
//   ready      : high only in RUN, always ~reset
//   loss_count : saturating count of lock losses seen in RUN
// Modports: master drives lock/clear, slave (the sequencer) drives status.
// -----------------------------------------------------------------------------
interface pll_lock_reset_if;
    import pll_pkg::*;

    logic              lock_async;
    logic              loss_clr;
    logic              reset;
    logic              ready;
    logic [LOSS_W-1:0] loss_count;

    modport master (
        output lock_async, loss_clr,
        input  reset, ready, loss_count
    );

    modport slave (
        input  lock_async, loss_clr,
        output reset, ready, loss_count
    );

endinterface

// File: rtl/pll_lock_reset_sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
// Plain flop-chain synchronizer, STAGES deep, asynchronously cleared to 0.
//   clock   : destination clock
//   reset_n : asynchronous active-low clear
//   d_i     : asynchronous input
//   q_o     : synchronized output (last flop of the chain)
// -----------------------------------------------------------------------------
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_reset.sv
// -----------------------------------------------------------------------------
// pll_lock_reset
// Holds the design in reset until the PLL has reported lock continuously for
// STABLE_CYCLES synchronized cycles, then for HOLD_CYCLES more, then releases.
// Any loss of lock sends the sequence back to the start.
//
// Ports:
//   clock   : PLL output clock, the only clock domain
//   reset_n : asynchronous active-low reset
//   bus     : pll_lock_reset_if.slave (lock_async, loss_clr in;
//             reset, ready, loss_count out)
//
// Build option: define PLL_LOCK_LOSS_COUNT_EN to build the lock-loss counter.
// Without it loss_count is tied to 0, loss_clr is ignored and no counter flops
// exist.
//
// Timing: from the first edge sampling lock_async=1, reset deasserts on edge
// SYNC_STAGES+1+STABLE_CYCLES+HOLD_CYCLES (counting that edge as 1).
// -----------------------------------------------------------------------------
module pll_lock_reset
    import pll_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    pll_lock_reset_if.slave  bus
);

    localparam int MAX_CYC = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = cnt_width(MAX_CYC);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("pll_lock_reset: SYNC_STAGES must be 2..4");
    end
    if (STABLE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_cyc
        $error("pll_lock_reset: STABLE_CYCLES and HOLD_CYCLES must be >= 1");
    end

    logic             lock_s;
    pll_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             reset_q, ready_q;
    logic             loss_evt;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d_i     (bus.lock_async),
        .q_o     (lock_s)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        loss_evt = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s) state_d = STABLE;
            end
            STABLE: begin
                // any dropout restarts qualification from zero
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!lock_s) begin
                    state_d  = WAIT_LOCK;
                    loss_evt = 1'b1;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // reset/ready decode the next state so they land on the same edge the
    // state does while still coming straight out of flops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            reset_q <= 1'b1;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            reset_q <= (state_d != RUN);
            ready_q <= (state_d == RUN);
        end
    end

    assign bus.reset = reset_q;
    assign bus.ready = ready_q;

`ifdef PLL_LOCK_LOSS_COUNT_EN
    logic [LOSS_W-1:0] loss_q, loss_d;

    // clear has priority over a same-cycle loss
    always_comb begin
        loss_d = loss_q;
        if (bus.loss_clr)                  loss_d = '0;
        else if (loss_evt && loss_q != '1) loss_d = loss_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) loss_q <= '0;
        else          loss_q <= loss_d;
    end

    assign bus.loss_count = loss_q;
`else
    logic unused_loss;
    assign unused_loss    = bus.loss_clr ^ loss_evt;
    assign bus.loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_lock_reset.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_reset
// Directed bench for pll_lock_reset with SYNC_STAGES=2, STABLE_CYCLES=8,
// HOLD_CYCLES=4 (15-edge release sequence). Loss-count expectations follow
// the PLL_LOCK_LOSS_COUNT_EN build option.
// -----------------------------------------------------------------------------
module tb_pll_lock_reset;
    import pll_pkg::*;

`ifdef PLL_LOCK_LOSS_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk   = 0;
    int   n_fail  = 0;
    int   exp_loss = 0;

    pll_lock_reset_if bus ();

    pll_lock_reset #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (8),
        .HOLD_CYCLES   (4)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // lock_async must already be high; counts edges until reset drops
    task automatic measure(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.reset !== 1'b0 && n < 60);
        check(tag, n, 15);
        check({tag, "_ready"}, {31'd0, bus.ready}, 1);
    endtask

    // drop lock while in RUN, count edges until reset reasserts
    task automatic lose(input string tag);
        int n;
        bus.lock_async = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.reset !== 1'b1 && n < 10);
        check(tag, n, 3);
        if (CNT_EN && exp_loss < 255) exp_loss++;
        check({tag, "_cnt"}, {24'd0, bus.loss_count}, exp_loss);
    endtask

    initial begin
        bus.lock_async = 1'b0;
        bus.loss_clr   = 1'b0;
        #12;
        check("por_reset", {31'd0, bus.reset}, 1);
        check("por_ready", {31'd0, bus.ready}, 0);
        check("por_loss",  {24'd0, bus.loss_count}, 0);

        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) tick();
        check("nolock_reset", {31'd0, bus.reset}, 1);

        // plain lock-up sequence
        bus.lock_async = 1'b1;
        measure("lock_seq");
        check("lock_seq_loss", {24'd0, bus.loss_count}, 0);

        // loss in RUN, then relock
        lose("run_loss");
        bus.lock_async = 1'b1;
        measure("relock");

        // glitch during STABLE at count 5 restarts qualification
        lose("pre_glitch_loss");
        bus.lock_async = 1'b1;
        repeat (8) tick();
        bus.lock_async = 1'b0;
        repeat (3) tick();
        check("glitch_reset", {31'd0, bus.reset}, 1);
        bus.lock_async = 1'b1;
        measure("glitch_restart");

        // saturation
        for (int i = 0; i < 300; i++) begin
            lose("sat_loss");
            bus.lock_async = 1'b1;
            measure("sat_relock");
        end
        check("sat_final", {24'd0, bus.loss_count}, CNT_EN ? 255 : 0);

        // async reset in the middle of HOLD
        lose("pre_hold_loss");
        bus.lock_async = 1'b1;
        repeat (12) tick();
        check("hold_reset", {31'd0, bus.reset}, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", {31'd0, bus.reset}, 1);
        check("async_ready", {31'd0, bus.ready}, 0);
        check("async_loss",  {24'd0, bus.loss_count}, 0);
        exp_loss = 0;
        tick();
        @(negedge clock);
        reset_n = 1'b1;
        measure("post_reset");

        // clear wins over a same-edge loss
        lose("pre_clr_loss");
        bus.lock_async = 1'b1;
        measure("pre_clr_relock");
        bus.lock_async = 1'b0;
        repeat (2) tick();
        check("clr_still_run", {31'd0, bus.reset}, 0);
        bus.loss_clr = 1'b1;
        tick();
        bus.loss_clr = 1'b0;
        exp_loss = 0;
        check("clr_reset", {31'd0, bus.reset}, 1);
        check("clr_wins",  {24'd0, bus.loss_count}, 0);

        // standalone clear
        bus.lock_async = 1'b1;
        measure("clr2_relock");
        lose("clr2_loss");
        bus.loss_clr = 1'b1;
        tick();
        bus.loss_clr = 1'b0;
        exp_loss = 0;
        check("clr_alone", {24'd0, bus.loss_count}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_lock_reset.md
PLL_LOCK_RESET -- requirements
Module: pll_lock_reset

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on lock_async, legal range 2..4.
REQ-002 SHALL have parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before hold, at least 1.
REQ-003 SHALL have parameter HOLD_CYCLES, default 16: extra reset cycles after lock is proven stable, at least 1.
REQ-004 SHALL have port clock, input, 1: single clock, the PLL output clock; everything is in this domain.
REQ-005 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port lock_async, input, 1: raw PLL LOCK, asynchronous to clock.
REQ-007 SHALL have port loss_clr, input, 1: synchronous clear of loss_count.
REQ-008 SHALL have port reset, output, 1: active-high design reset, asserted in every state except RUN.
REQ-009 SHALL have port ready, output, 1: high only in RUN; always equal to ~reset.
REQ-010 SHALL have port loss_count, output, 8: saturating count of lock losses seen in RUN.

Function
REQ-011 SHALL pass lock_async through SYNC_STAGES flops to form lock_s; no other logic reads lock_async.
REQ-012 SHALL implement FSM states WAIT_LOCK, STABLE, HOLD, RUN, plus one cycle counter sized for max(STABLE_CYCLES, HOLD_CYCLES)-1.
REQ-013 WAIT_LOCK: when lock_s=1 go to STABLE with counter=0; otherwise stay.
REQ-014 STABLE: when lock_s=0 go to WAIT_LOCK and clear the counter; when counter=STABLE_CYCLES-1 go to HOLD with counter=0; otherwise increment the counter.
REQ-015 HOLD: when lock_s=0 go to WAIT_LOCK; when counter=HOLD_CYCLES-1 go to RUN; otherwise increment the counter.
REQ-016 RUN: when lock_s=0 go to WAIT_LOCK next edge, and increment loss_count, saturating at 255.
REQ-017 reset and ready SHALL be registered state decodes with no combinational path from any input.
REQ-018 From the first edge that samples lock_async=1 with lock held, reset SHALL deassert after exactly SYNC_STAGES+1+STABLE_CYCLES+HOLD_CYCLES edges.
REQ-019 loss_clr SHALL zero loss_count at the next edge; loss_clr together with a RUN loss in the same cycle yields 0 (clear wins).
REQ-020 A lock glitch shorter than STABLE_CYCLES during STABLE SHALL restart qualification from zero; no partial credit.

Reset
REQ-021 reset_n low SHALL asynchronously force: all sync flops 0, state WAIT_LOCK, counter 0, reset=1, ready=0, loss_count=0.
REQ-022 reset_n release SHALL be synchronous-safe: outputs change only on clock edges after release; reset stays 1 until the full REQ-018 sequence completes.

Configuration
REQ-023 With macro PLL_LOCK_LOSS_COUNT_EN defined, loss_count and loss_clr SHALL behave per REQ-016/019.
REQ-024 Without PLL_LOCK_LOSS_COUNT_EN, loss_count SHALL be constant 0, loss_clr SHALL be ignored, and no counter flops are built.

Structure
REQ-025 SHALL place the FSM state enum (2-bit) and the loss-count width constant (8) in shared package pll_pkg.
REQ-026 SHALL implement the synchronizer as sub-module sync_chain (parameter STAGES, async active-low clear to 0), instantiated once.

Verification (SYNC_STAGES=2, STABLE_CYCLES=8, HOLD_CYCLES=4)
REQ-027 Release reset_n, then raise lock_async before edge k and hold it -> reset=1 through edge k+13; reset=0, ready=1 after edge k+14; loss_count=0.
REQ-028 In STABLE, pulse lock_async low for 3 cycles at qualification count 5 -> return to WAIT_LOCK; the deassert time is re-measured as 15 edges from the new rising lock sample.
REQ-029 In RUN, drop lock_async -> reset=1 two to three edges later; loss_count=1; relock gives the full 15-edge sequence again.
REQ-030 Force 300 RUN losses -> loss_count saturates at 255; assert loss_clr on the same edge as a loss -> loss_count=0.
REQ-031 Assert reset_n low mid-HOLD, between edges -> reset=1, ready=0, loss_count=0 immediately, without waiting for an edge.
REQ-032 Build without PLL_LOCK_LOSS_COUNT_EN and repeat REQ-029 -> loss_count stays 0.
